// File: rtl/rilib_bias_pkg.sv
// Shared definitions for the well-bias ramp sequencer.
//  - default channel count, code width and reset code
//  - sequencer state encoding
//  - ch_lsb(): bit offset of a channel's code inside a packed multi-channel vector
package rilib_bias_pkg;

    localparam int unsigned BIAS_N_CH     = 2;
    localparam int unsigned BIAS_CODE_W   = 6;
    localparam int unsigned BIAS_RST_CODE = 0;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StScan    = 3'd1,
        StStep    = 3'd2,
        StWaitAck = 3'd3,
        StSettle  = 3'd4,
        StErr     = 3'd5
    } bias_state_e;

    // Channel k occupies bits [k*code_w +: code_w].
    function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned code_w);
        return ch * code_w;
    endfunction

endpackage

// File: rtl/rilib_bias_timer.sv
// Loadable down-counter shared between the ack-timeout and settle intervals.
// Ports:
//  i_clk      clock
//  i_rst_n    synchronous reset, active low (count -> 0)
//  i_load     load i_load_val (has priority over i_dec)
//  i_load_val value to load
//  i_dec      decrement by one, saturating at zero
//  o_zero     count is zero
module rilib_bias_timer #(
    parameter int unsigned W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/rilib_bias_ramp_seq.sv
// Back-gate well-bias ramp sequencer. Walks every channel's DAC code one LSB at a time
// toward a latched target, round-robin across channels, with a req/ack handshake per step
// and a programmable settle interval after each accepted step.
// Ports:
//  i_clk, i_rst_n   clock, synchronous active-low reset
//  i_en             enable; low returns to idle next cycle, codes hold
//  i_start          pulse: latch i_tgt_code and begin a ramp (ignored while busy)
//  i_tgt_code       packed target codes, channel k at [k*CODE_W +: CODE_W]
//  i_step_div       settle cycles after each acked step (0 -> one settle cycle)
//  o_bias_code      current packed codes to the bias generator (registered)
//  o_bias_req       step request, held until i_bias_ack
//  o_bias_ch        channel being stepped, valid while o_bias_req
//  i_bias_ack       generator accepted the step
//  o_busy           ramp in progress
//  o_done           one-cycle pulse on the final matching scan
//  o_err_tmo        sticky ack-timeout flag, cleared by the next start
module rilib_bias_ramp_seq
    import rilib_bias_pkg::*;
#(
    parameter int unsigned N_CH     = BIAS_N_CH,
    parameter int unsigned CODE_W   = BIAS_CODE_W,
    parameter int unsigned RST_CODE = BIAS_RST_CODE,
    parameter int unsigned DIV_W    = 8,
    parameter int unsigned TMO_CYC  = 255,
    localparam int unsigned CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_en,
    input  logic                     i_start,
    input  logic [N_CH*CODE_W-1:0]   i_tgt_code,
    input  logic [DIV_W-1:0]         i_step_div,
    output logic [N_CH*CODE_W-1:0]   o_bias_code,
    output logic                     o_bias_req,
    output logic [CH_W-1:0]          o_bias_ch,
    input  logic                     i_bias_ack,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_err_tmo
);

    localparam int unsigned TMO_W = $clog2(TMO_CYC + 1);
    localparam int unsigned TMR_W = (DIV_W > TMO_W) ? DIV_W : TMO_W;
    localparam int unsigned MC_W  = $clog2(N_CH + 1);
    localparam int unsigned VEC_W = N_CH * CODE_W;

    localparam logic [CODE_W-1:0] RST_CODE_V = CODE_W'(RST_CODE);
    // Timer expires on reaching zero, so TMO_CYC-1 gives exactly TMO_CYC wait cycles.
    localparam logic [TMR_W-1:0]  TMO_LOAD   = TMR_W'(TMO_CYC - 1);
    localparam logic [CH_W-1:0]   LAST_CH    = CH_W'(N_CH - 1);
    localparam logic [MC_W-1:0]   LAST_MC    = MC_W'(N_CH - 1);

    bias_state_e        r_state, w_state_nxt;
    logic [CH_W-1:0]    r_ptr, w_ptr_nxt, w_ptr_inc;
    logic [MC_W-1:0]    r_match_cnt, w_match_cnt_nxt;
    logic [VEC_W-1:0]   r_code, w_code_nxt;
    logic [VEC_W-1:0]   r_tgt, w_tgt_nxt;
    logic               r_err_tmo, w_err_tmo_nxt;
    logic [CODE_W-1:0]  w_cur_code, w_cur_tgt;
    logic               w_tmr_load, w_tmr_dec, w_tmr_zero;
    logic [TMR_W-1:0]   w_tmr_val;
    logic               w_done;

    assign w_cur_code = r_code[ch_lsb(32'(r_ptr), CODE_W) +: CODE_W];
    assign w_cur_tgt  = r_tgt[ch_lsb(32'(r_ptr), CODE_W) +: CODE_W];
    assign w_ptr_inc  = (r_ptr == LAST_CH) ? '0 : r_ptr + 1'b1;

    rilib_bias_timer #(
        .W (TMR_W)
    ) u_timer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_dec      (w_tmr_dec),
        .o_zero     (w_tmr_zero)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_ptr       <= '0;
            r_match_cnt <= '0;
            r_code      <= {N_CH{RST_CODE_V}};
            r_tgt       <= {N_CH{RST_CODE_V}};
            r_err_tmo   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_match_cnt <= w_match_cnt_nxt;
            r_code      <= w_code_nxt;
            r_tgt       <= w_tgt_nxt;
            r_err_tmo   <= w_err_tmo_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_match_cnt_nxt = r_match_cnt;
        w_code_nxt      = r_code;
        w_tgt_nxt       = r_tgt;
        w_err_tmo_nxt   = r_err_tmo;
        w_tmr_load      = 1'b0;
        w_tmr_val       = '0;
        w_tmr_dec       = 1'b0;
        w_done          = 1'b0;

        if (!i_en) begin
            // Abort: codes and the error flag hold, no done.
            w_state_nxt = StIdle;
        end else begin
            case (r_state)
                StIdle, StErr: begin
                    if (i_start) begin
                        w_tgt_nxt       = i_tgt_code;
                        w_err_tmo_nxt   = 1'b0;
                        w_ptr_nxt       = '0;
                        w_match_cnt_nxt = '0;
                        w_state_nxt     = StScan;
                    end
                end
                StScan: begin
                    if (w_cur_code != w_cur_tgt) begin
                        w_match_cnt_nxt = '0;
                        w_state_nxt     = StStep;
                    end else begin
                        w_ptr_nxt = w_ptr_inc;
                        // N_CH consecutive matches means every channel is on target.
                        if (r_match_cnt == LAST_MC) begin
                            w_done          = 1'b1;
                            w_match_cnt_nxt = '0;
                            w_state_nxt     = StIdle;
                        end else begin
                            w_match_cnt_nxt = r_match_cnt + 1'b1;
                        end
                    end
                end
                StStep: begin
                    w_code_nxt[ch_lsb(32'(r_ptr), CODE_W) +: CODE_W] =
                        (w_cur_code < w_cur_tgt) ? w_cur_code + 1'b1 : w_cur_code - 1'b1;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = TMO_LOAD;
                    w_state_nxt = StWaitAck;
                end
                StWaitAck: begin
                    // Ack wins over a timeout expiring in the same cycle.
                    if (i_bias_ack) begin
                        w_ptr_nxt   = w_ptr_inc;
                        w_tmr_load  = 1'b1;
                        w_tmr_val   = TMR_W'(i_step_div);
                        w_state_nxt = StSettle;
                    end else if (w_tmr_zero) begin
                        w_err_tmo_nxt = 1'b1;
                        w_state_nxt   = StErr;
                    end else begin
                        w_tmr_dec = 1'b1;
                    end
                end
                StSettle: begin
                    if (w_tmr_zero) begin
                        w_state_nxt = StScan;
                    end else begin
                        w_tmr_dec = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = StIdle;
                end
            endcase
        end
    end

    assign o_bias_code = r_code;
    assign o_bias_req  = (r_state == StWaitAck);
    assign o_bias_ch   = r_ptr;
    assign o_busy      = (r_state == StScan) || (r_state == StStep) ||
                         (r_state == StWaitAck) || (r_state == StSettle);
    assign o_done      = w_done;
    assign o_err_tmo   = r_err_tmo;

endmodule

// File: tb/tb_rilib_bias_ramp_seq.sv
// Self-checking bench for rilib_bias_ramp_seq (2 channels, 6-bit codes, 4-cycle ack timeout).
module tb_rilib_bias_ramp_seq;

    localparam int N_CH    = 2;
    localparam int CODE_W  = 6;
    localparam int DIV_W   = 8;
    localparam int TMO_CYC = 4;

    logic        clk = 1'b0;
    logic        rst_n, en, start, ack;
    logic [11:0] tgt;
    logic [7:0]  step_div;
    logic [11:0] code;
    logic        req, ch, busy, done, err;

    always #5 clk = ~clk;

    rilib_bias_ramp_seq #(
        .N_CH     (N_CH),
        .CODE_W   (CODE_W),
        .RST_CODE (0),
        .DIV_W    (DIV_W),
        .TMO_CYC  (TMO_CYC)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_en        (en),
        .i_start     (start),
        .i_tgt_code  (tgt),
        .i_step_div  (step_div),
        .o_bias_code (code),
        .o_bias_req  (req),
        .o_bias_ch   (ch),
        .i_bias_ack  (ack),
        .o_busy      (busy),
        .o_done      (done),
        .o_err_tmo   (err)
    );

    typedef struct {
        logic [11:0] tgt;
        int          sd;
        int          dly;
        bit          start_on_done;
    } vec_t;

    typedef struct {
        logic        ch;
        logic [11:0] code;
        int          cyc;
    } step_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    step_t       exp_q[$];
    logic [11:0] m_code;
    int          ack_dly  = 0;
    bit          ack_en   = 1'b0;
    int          ack_wait = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Generator model: ack for one cycle after ack_dly+1 cycles of request.
    initial begin
        ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ack_en) begin
                if (ack) begin
                    ack = 1'b0;
                end else if (req) begin
                    if (ack_wait >= ack_dly) begin
                        ack      = 1'b1;
                        ack_wait = 0;
                    end else begin
                        ack_wait++;
                    end
                end else begin
                    ack_wait = 0;
                end
            end
        end
    end

    // Reference ramp: round-robin from ch0, one LSB per step, done after N_CH
    // consecutive on-target channels. Pushes each expected step and returns the
    // cycle (counted from the start edge) in which done is expected.
    task automatic model_ramp(input logic [11:0] t_vec, input int sd, input int dly,
                              output int done_cyc);
        int    ptr, mc, cyc, c, t;
        step_t s;
        ptr = 0;
        mc  = 0;
        cyc = 0;
        while (mc < N_CH) begin
            cyc++;
            c = int'(m_code[ptr*CODE_W +: CODE_W]);
            t = int'(t_vec[ptr*CODE_W +: CODE_W]);
            if (c != t) begin
                c = (c < t) ? c + 1 : c - 1;
                m_code[ptr*CODE_W +: CODE_W] = 6'(c);
                s.ch   = 1'(ptr);
                s.code = m_code;
                s.cyc  = cyc + 2;
                exp_q.push_back(s);
                cyc += 1 + (dly + 1) + (sd + 1);
                mc = 0;
            end else begin
                mc++;
            end
            ptr = (ptr + 1) % N_CH;
        end
        done_cyc = cyc;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int    exp_cyc, cyc;
        bit    prev_req, seen_done;
        step_t s;
        step_div = 8'(v.sd);
        ack_dly  = v.dly;
        ack_en   = 1'b1;
        model_ramp(v.tgt, v.sd, v.dly, exp_cyc);
        @(negedge clk);
        tgt   = v.tgt;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        tgt   = ~v.tgt;   // must not affect the ramp in progress
        cyc       = 0;
        prev_req  = 1'b0;
        seen_done = 1'b0;
        while (!seen_done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (req && !prev_req) begin
                if (exp_q.size() == 0) begin
                    check({tag, " unexpected req"}, 32'd1, 32'd0);
                end else begin
                    s = exp_q.pop_front();
                    check({tag, " step ch"}, 32'(ch), 32'(s.ch));
                    check({tag, " step code"}, 32'(code), 32'(s.code));
                    check({tag, " req cycle"}, 32'(cyc), 32'(s.cyc));
                end
            end
            prev_req = req;
            if (done) begin
                seen_done = 1'b1;
                check({tag, " done cycle"}, 32'(cyc), 32'(exp_cyc));
                if (v.start_on_done) begin
                    start = 1'b1;
                    tgt   = ~v.tgt;
                end
            end
        end
        if (!seen_done) check({tag, " done timeout"}, 32'd0, 32'd1);
        check({tag, " steps left"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        if (v.start_on_done) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        @(negedge clk);
        check({tag, " busy after"}, 32'(busy), 32'd0);
        check({tag, " done pulse"}, 32'(done), 32'd0);
        check({tag, " final code"}, 32'(code), 32'(m_code));
        check({tag, " err"}, 32'(err), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        int   n_req;
        bit   seen;

        // {ch1, ch0} targets
        vecs[0] = '{tgt: {6'd0,  6'd3},  sd: 2, dly: 1, start_on_done: 1'b0};
        vecs[1] = '{tgt: {6'd0,  6'd0},  sd: 0, dly: 0, start_on_done: 1'b0};
        vecs[2] = '{tgt: {6'd2,  6'd2},  sd: 1, dly: 2, start_on_done: 1'b0};
        vecs[3] = '{tgt: {6'd5,  6'd5},  sd: 0, dly: 3, start_on_done: 1'b0}; // ack on expiry
        vecs[4] = '{tgt: {6'd3,  6'd3},  sd: 3, dly: 0, start_on_done: 1'b0};
        vecs[5] = '{tgt: {6'd3,  6'd3},  sd: 0, dly: 0, start_on_done: 1'b1};
        vecs[6] = '{tgt: {6'd0,  6'd63}, sd: 0, dly: 0, start_on_done: 1'b0};
        vecs[7] = '{tgt: {6'd63, 6'd0},  sd: 0, dly: 1, start_on_done: 1'b0};

        rst_n    = 1'b0;
        en       = 1'b1;
        start    = 1'b0;
        tgt      = 12'h000;
        step_div = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        m_code = 12'h000;
        @(negedge clk);
        check("reset code", 32'(code), 32'h0);
        check("reset req", 32'(req), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset err", 32'(err), 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Ack withheld: timeout after TMO_CYC request cycles, sticky error.
        ack_en = 1'b0;
        ack    = 1'b0;
        @(negedge clk);
        tgt   = {6'd63, 6'd1};
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        m_code[5:0] = 6'd1;
        n_req = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req) n_req++;
        end
        check("tmo req cycles", 32'(n_req), 32'(TMO_CYC));
        check("tmo err", 32'(err), 32'd1);
        check("tmo busy", 32'(busy), 32'd0);
        check("tmo req low", 32'(req), 32'd0);
        check("tmo code held", 32'(code), 32'(m_code));
        // Restart clears the error and resumes.
        @(negedge clk);
        start = 1'b1;
        tgt   = {6'd63, 6'd2};
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("restart err clr", 32'(err), 32'd0);
        check("restart busy", 32'(busy), 32'd1);
        ack_en = 1'b1;
        ack_dly = 0;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        m_code[5:0] = 6'd2;
        check("restart done", 32'(seen), 32'd1);
        @(negedge clk);
        check("restart code", 32'(code), 32'(m_code));

        // en dropped while waiting for ack.
        ack_en = 1'b0;
        ack    = 1'b0;
        @(negedge clk);
        tgt   = {6'd63, 6'd5};
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (req) seen = 1'b1;
        end
        check("en req seen", 32'(seen), 32'd1);
        m_code[5:0] = 6'd3;
        en = 1'b0;
        @(negedge clk);
        check("en drop req", 32'(req), 32'd0);
        check("en drop busy", 32'(busy), 32'd0);
        check("en drop code", 32'(code), 32'(m_code));
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("en drop no done", 32'(seen), 32'd0);
        en = 1'b1;

        // Stray ack with no request is ignored.
        ack = 1'b1;
        repeat (3) @(negedge clk);
        ack = 1'b0;
        check("stray ack code", 32'(code), 32'(m_code));
        check("stray ack busy", 32'(busy), 32'd0);

        // Start while busy is ignored, including its new target.
        ack_en   = 1'b1;
        ack_dly  = 0;
        step_div = 8'd1;
        @(negedge clk);
        tgt   = {6'd63, 6'd9};
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        tgt   = 12'h000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("busy start done", 32'(seen), 32'd1);
        m_code = {6'd63, 6'd9};
        @(negedge clk);
        check("busy start code", 32'(code), 32'(m_code));

        // Reset in the middle of a ramp.
        @(negedge clk);
        tgt   = {6'd0, 6'd20};
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(negedge clk);
        check("mid busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid rst code", 32'(code), 32'h0);
        check("mid rst req", 32'(req), 32'd0);
        check("mid rst busy", 32'(busy), 32'd0);
        check("mid rst done", 32'(done), 32'd0);
        check("mid rst err", 32'(err), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
